// File: rtl/fpadd_issue_if.sv
// rtl/fpadd_issue_if.sv - producer, adder, result and status signals of the FP adder issue controller
interface fpadd_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic          add_start;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_done;
    logic [31:0]   add_sum;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic          out_err;
    logic [CW-1:0] fifo_count;
    logic          busy;

    modport master (
        output in_valid, in_a, in_b, add_done, add_sum, out_ready,
        input  in_ready, add_start, add_a, add_b, out_valid, out_sum, out_err, fifo_count, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, add_done, add_sum, out_ready,
        output in_ready, add_start, add_a, add_b, out_valid, out_sum, out_err, fifo_count, busy
    );
endinterface

// File: rtl/fpadd_issue.sv
// rtl/fpadd_issue.sv - operand FIFO and start/done issue controller for the multicycle FP adder
// Optional WAIT watchdog enabled by defining FPADD_TIMEOUT_EN.
module fpadd_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          reset,
    fpadd_issue_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_GUARD  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fpadd_issue: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fpadd_issue: TIMEOUT must fit the 8-bit watchdog");
    end

    logic [2:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_a [DEPTH];
    logic [31:0]   r_mem_b [DEPTH];
    logic [31:0]   r_op_a;
    logic [31:0]   r_op_b;
    logic [31:0]   r_out_sum;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;

`ifdef FPADD_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wd;
    logic       r_out_err;
`endif

    // Ready looks only at the registered count, so a pop never ripples into in_ready.
    assign w_in_ready = reset && (r_count != FULL);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_out_sum <= '0;
`ifdef FPADD_TIMEOUT_EN
            r_wd      <= '0;
            r_out_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op_a  <= r_mem_a[r_rd_ptr];
                        r_op_b  <= r_mem_b[r_rd_ptr];
                        r_state <= S_START;
                    end
                end
                S_START: r_state <= S_GUARD;
                // The adder's done level from the previous op is still up here; skip it.
                S_GUARD: begin
`ifdef FPADD_TIMEOUT_EN
                    r_wd <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.add_done) begin
                        r_out_sum <= bus.add_sum;
`ifdef FPADD_TIMEOUT_EN
                        r_out_err <= 1'b0;
`endif
                        r_state   <= S_RESULT;
                    end
`ifdef FPADD_TIMEOUT_EN
                    else if (r_wd == WD_LAST) begin
                        r_out_sum <= 32'h7FC0_0000;
                        r_out_err <= 1'b1;
                        r_state   <= S_RESULT;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
`endif
                end
                S_RESULT: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.add_start  = (r_state == S_START);
    assign bus.add_a      = r_op_a;
    assign bus.add_b      = r_op_b;
    assign bus.out_valid  = (r_state == S_RESULT);
    assign bus.out_sum    = r_out_sum;
    assign bus.fifo_count = r_count;
    assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
`ifdef FPADD_TIMEOUT_EN
    assign bus.out_err    = r_out_err;
`else
    assign bus.out_err    = 1'b0;
`endif
endmodule

// File: tb/tb_fpadd_issue.sv
// tb/tb_fpadd_issue.sv - randomized self-checking bench for fpadd_issue with a behavioural adder and scoreboard
module tb_fpadd_issue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpadd_issue_if #(.DEPTH(DEPTH)) bus ();
    fpadd_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_res[$];
    int          start_cycles[$];
    int          cyc = 0, n_starts = 0, n_results = 0, n_accepts = 0;
    int          last_accept_cyc = 0, last_start_cyc = 0, last_valid_rise_cyc = 0;
    bit          prev_valid = 0, in_flight = 0, stall = 0, expect_to = 0, rnd_ready = 0;
    int          lat_min = 10, lat_max = 10;
    int          t_clear = -1, t_done = -1;
    logic [31:0] pend_sum, cur_a, cur_b, exp_sum;

    // Adder model plus scoreboard: samples on the falling edge, drives just after the rising edge.
    initial begin
        bus.add_done = 1'b0;
        bus.add_sum  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q_a.delete(); q_b.delete(); q_res.delete();
                in_flight  = 0;
                prev_valid = 0;
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    q_a.push_back(bus.in_a);
                    q_b.push_back(bus.in_b);
                    n_accepts++;
                    last_accept_cyc = cyc;
                end
                if (in_flight) begin
                    check("add_a_hold", bus.add_a, cur_a);
                    check("add_b_hold", bus.add_b, cur_b);
                end
                if (bus.add_start) begin
                    check("no_overlap", 32'(in_flight), 32'd0);
                    check("start_has_pair", 32'(q_a.size() != 0), 32'd1);
                    if (q_a.size() != 0) begin
                        cur_a = q_a.pop_front();
                        cur_b = q_b.pop_front();
                        check("add_a", bus.add_a, cur_a);
                        check("add_b", bus.add_b, cur_b);
                        q_res.push_back(model_sum(cur_a, cur_b));
                    end
                    in_flight = 1;
                    n_starts++;
                    last_start_cyc = cyc;
                    start_cycles.push_back(cyc);
                    t_clear  = cyc + 2;
                    t_done   = cyc + int'($urandom_range(lat_min, lat_max));
                    pend_sum = model_sum(bus.add_a, bus.add_b);
                end
                if (bus.out_valid && !prev_valid) last_valid_rise_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    check("result_expected", 32'(q_res.size() != 0), 32'd1);
                    if (q_res.size() != 0) begin
                        exp_sum = q_res.pop_front();
                        if (expect_to) exp_sum = 32'h7FC0_0000;
                        check("out_sum", bus.out_sum, exp_sum);
                        check("out_err", 32'(bus.out_err), 32'(expect_to));
                    end
                    in_flight = 0;
                    n_results++;
                end
                prev_valid = bus.out_valid;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == t_clear) bus.add_done = 1'b0;
            if (!stall && t_done >= 0 && cyc >= t_done) begin
                bus.add_done = 1'b1;
                bus.add_sum  = pend_sum;
                t_done       = -1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        check("push_accepted", 32'(ok), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (!bus.busy && !in_flight && q_res.size() == 0) begin
                idle = 1;
                break;
            end
        end
        check("drained", 32'(idle), 32'd1);
    endtask

    int base_s, base_r, base_acc;

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        tick(3);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_add_start", 32'(bus.add_start), 32'd0);
        check("rst_add_a", bus.add_a, 32'd0);
        check("rst_add_b", bus.add_b, 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", bus.out_sum, 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        tick(1);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single op, fixed 10-cycle adder.
        base_s = n_starts;
        push_pair(32'h3F80_0000, 32'h4000_0000);
        wait_idle(100);
        check("one_start", 32'(n_starts - base_s), 32'd1);
        check("accept_to_start", 32'(last_start_cyc - last_accept_cyc), 32'd2);
        check("start_to_valid", 32'(last_valid_rise_cyc - last_start_cyc), 32'd11);

        // Fastest adder: start pulses 5 cycles apart.
        lat_min = 2; lat_max = 2;
        start_cycles.delete();
        for (int i = 0; i < 3; i++) push_pair($urandom(), $urandom());
        wait_idle(100);
        check("spacing_n", 32'(start_cycles.size()), 32'd3);
        if (start_cycles.size() == 3) begin
            check("spacing_1", 32'(start_cycles[1] - start_cycles[0]), 32'd5);
            check("spacing_2", 32'(start_cycles[2] - start_cycles[1]), 32'd5);
        end

        // Stalled adder: 5 accepts fill holding + FIFO, the sixth waits.
        lat_min = 4; lat_max = 8;
        stall = 1; base_acc = n_accepts; base_r = n_results;
        for (int i = 0; i < 5; i++) push_pair($urandom(), $urandom());
        bus.in_valid = 1'b1; bus.in_a = $urandom(); bus.in_b = $urandom();
        tick(10);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_accepts", 32'(n_accepts - base_acc), 32'd5);
        check("full_count", 32'(bus.fifo_count), 32'd4);
        stall = 0;
        push_pair(bus.in_a, bus.in_b);
        wait_idle(500);
        check("six_results", 32'(n_results - base_r), 32'd6);

        // Result held with out_ready low while the FIFO fills.
        lat_min = 3; lat_max = 3;
        bus.out_ready = 1'b0;
        push_pair($urandom(), $urandom());
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.out_valid) break;
        end
        check("hold_valid_seen", 32'(bus.out_valid), 32'd1);
        base_s = n_starts;
        for (int i = 0; i < 4; i++) push_pair($urandom(), $urandom());
        tick(16);
        check("hold_sum", bus.out_sum, (q_res.size() != 0) ? q_res[0] : 32'hxxxx_xxxx);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_no_start", 32'(n_starts - base_s), 32'd0);
        check("hold_count", 32'(bus.fifo_count), 32'd4);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        wait_idle(500);

        // Stale done from the previous op overlaps START/GUARD of the next.
        lat_min = 5; lat_max = 5;
        push_pair($urandom(), $urandom());
        push_pair($urandom(), $urandom());
        wait_idle(200);
        check("stale_done_latency", 32'(last_valid_rise_cyc - last_start_cyc), 32'd6);

        // Reset during WAIT with two entries queued.
        stall = 1;
        for (int i = 0; i < 3; i++) push_pair($urandom(), $urandom());
        tick(3);
        check("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        stall = 0;
        base_r = n_results;
        tick(1);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        tick(30);
        check("rel_no_result", 32'(n_results - base_r), 32'd0);
        check("rel_busy", 32'(bus.busy), 32'd0);

        // Randomized traffic, latencies and consumer backpressure.
        lat_min = 2; lat_max = 12;
        base_r = n_results;
        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            push_pair($urandom(), $urandom());
            tick(int'($urandom_range(0, 3)));
        end
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        wait_idle(2000);
        check("rnd_results", 32'(n_results - base_r), 32'd40);
        check("rnd_queue_empty", 32'(q_a.size()), 32'd0);

`ifdef FPADD_TIMEOUT_EN
        stall = 1; expect_to = 1;
        push_pair($urandom(), $urandom());
        wait_idle(500);
        check("timeout_latency", 32'(last_valid_rise_cyc - last_start_cyc), 32'(TIMEOUT + 2));
        expect_to = 0; stall = 0;
        tick(5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
